// File: rtl/pcie_tlp_cpl_fifo.sv
// Store-and-forward completion TLP FIFO: beats and per-packet headers are buffered and a packet
// is presented downstream only once its eop beat has been stored.
module pcie_tlp_cpl_fifo #(
  parameter int unsigned TLP_DATA_WIDTH = 256,
  parameter int unsigned TLP_STRB_WIDTH = 8,
  parameter int unsigned TLP_HDR_WIDTH  = 128,
  parameter int unsigned DATA_DEPTH     = 16,
  parameter int unsigned HDR_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [TLP_DATA_WIDTH-1:0]    s_tlp_data,
  input  logic [TLP_STRB_WIDTH-1:0]    s_tlp_strb,
  input  logic [TLP_HDR_WIDTH-1:0]     s_tlp_hdr,
  input  logic                         s_tlp_valid,
  input  logic                         s_tlp_sop,
  input  logic                         s_tlp_eop,
  output logic                         s_tlp_ready,
  output logic [TLP_DATA_WIDTH-1:0]    tx_cpl_tlp_data,
  output logic [TLP_STRB_WIDTH-1:0]    tx_cpl_tlp_strb,
  output logic [TLP_HDR_WIDTH-1:0]     tx_cpl_tlp_hdr,
  output logic                         tx_cpl_tlp_valid,
  output logic                         tx_cpl_tlp_sop,
  output logic                         tx_cpl_tlp_eop,
  input  logic                         tx_cpl_tlp_ready,
  output logic [$clog2(HDR_DEPTH):0]   pkt_count,
  output logic                         status_error_framing
);

  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned HAW = $clog2(HDR_DEPTH);
  localparam logic [DAW:0] DataFullXor = (DAW + 1)'(DATA_DEPTH);
  localparam logic [HAW:0] HdrFullXor  = (HAW + 1)'(HDR_DEPTH);
  localparam logic [DAW:0] DataOne     = (DAW + 1)'(1);
  localparam logic [HAW:0] HdrOne      = (HAW + 1)'(1);

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  state_e state_q;

  logic [TLP_DATA_WIDTH-1:0] data_mem [DATA_DEPTH];
  logic [TLP_STRB_WIDTH-1:0] strb_mem [DATA_DEPTH];
  logic                      sop_mem  [DATA_DEPTH];
  logic                      eop_mem  [DATA_DEPTH];
  logic [TLP_HDR_WIDTH-1:0]  hdr_mem  [HDR_DEPTH];

  // wr: next write, cmt: end of last committed packet, ld: next beat into the output
  // register, rd: oldest beat not yet handed downstream (occupancy includes the output register).
  logic [DAW:0] wr_ptr_q, cmt_ptr_q, ld_ptr_q, rd_ptr_q;
  logic [HAW:0] hdr_wr_ptr_q, hdr_ld_ptr_q, hdr_rd_ptr_q;
  logic [HAW:0] pkt_count_q;
  logic         ready_en_q, err_q;

  logic [TLP_DATA_WIDTH-1:0] out_data_q;
  logic [TLP_STRB_WIDTH-1:0] out_strb_q;
  logic [TLP_HDR_WIDTH-1:0]  out_hdr_q;
  logic                      out_valid_q, out_sop_q, out_eop_q;

  logic data_full, hdr_full;
  logic in_acc, in_write, in_commit, hdr_write;
  logic beat_avail, out_load, out_pop, eop_pop;
  logic [DAW-1:0] wr_idx, ld_idx;

  assign data_full = (wr_ptr_q ^ rd_ptr_q) == DataFullXor;
  assign hdr_full  = (hdr_wr_ptr_q ^ hdr_rd_ptr_q) == HdrFullXor;

  assign s_tlp_ready = ready_en_q && !data_full && ((state_q == StInPkt) || !hdr_full);

  assign in_acc    = s_tlp_valid && s_tlp_ready;
  assign in_write  = in_acc && ((state_q == StInPkt) || s_tlp_sop);
  assign in_commit = in_write && s_tlp_eop;
  assign hdr_write = in_acc && (state_q == StIdle) && s_tlp_sop;

  assign wr_idx     = wr_ptr_q[DAW-1:0];
  assign ld_idx     = ld_ptr_q[DAW-1:0];
  assign beat_avail = ld_ptr_q != cmt_ptr_q;
  assign out_pop    = out_valid_q && tx_cpl_tlp_ready;
  assign out_load   = beat_avail && (!out_valid_q || tx_cpl_tlp_ready);
  assign eop_pop    = out_pop && out_eop_q;

  always_ff @(posedge clk) begin
    if (in_write) begin
      data_mem[wr_idx] <= s_tlp_data;
      strb_mem[wr_idx] <= s_tlp_strb;
      sop_mem[wr_idx]  <= (state_q == StIdle);
      eop_mem[wr_idx]  <= s_tlp_eop;
    end
    if (hdr_write) begin
      hdr_mem[hdr_wr_ptr_q[HAW-1:0]] <= s_tlp_hdr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ready_en_q   <= 1'b0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      cmt_ptr_q    <= '0;
      ld_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hdr_wr_ptr_q <= '0;
      hdr_ld_ptr_q <= '0;
      hdr_rd_ptr_q <= '0;
      pkt_count_q  <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_hdr_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      err_q      <= in_acc && ((state_q == StIdle) ? !s_tlp_sop : s_tlp_sop);

      if (in_acc) begin
        if (state_q == StIdle) begin
          if (s_tlp_sop && !s_tlp_eop) state_q <= StInPkt;
        end else if (s_tlp_eop) begin
          state_q <= StIdle;
        end
      end

      if (in_write)  wr_ptr_q     <= wr_ptr_q + DataOne;
      if (in_commit) cmt_ptr_q    <= wr_ptr_q + DataOne;
      if (hdr_write) hdr_wr_ptr_q <= hdr_wr_ptr_q + HdrOne;
      if (out_pop)   rd_ptr_q     <= rd_ptr_q + DataOne;
      if (eop_pop)   hdr_rd_ptr_q <= hdr_rd_ptr_q + HdrOne;

      if (in_commit && !eop_pop) begin
        pkt_count_q <= pkt_count_q + HdrOne;
      end else if (!in_commit && eop_pop) begin
        pkt_count_q <= pkt_count_q - HdrOne;
      end

      if (out_load) begin
        ld_ptr_q    <= ld_ptr_q + DataOne;
        out_valid_q <= 1'b1;
        out_data_q  <= data_mem[ld_idx];
        out_strb_q  <= strb_mem[ld_idx];
        out_sop_q   <= sop_mem[ld_idx];
        out_eop_q   <= eop_mem[ld_idx];
        // Header is latched with the first beat so it stays stable for the whole packet.
        if (sop_mem[ld_idx]) begin
          out_hdr_q    <= hdr_mem[hdr_ld_ptr_q[HAW-1:0]];
          hdr_ld_ptr_q <= hdr_ld_ptr_q + HdrOne;
        end
      end else if (out_pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign tx_cpl_tlp_data      = out_data_q;
  assign tx_cpl_tlp_strb      = out_strb_q;
  assign tx_cpl_tlp_hdr       = out_hdr_q;
  assign tx_cpl_tlp_valid     = out_valid_q;
  assign tx_cpl_tlp_sop       = out_sop_q;
  assign tx_cpl_tlp_eop       = out_eop_q;
  assign pkt_count            = pkt_count_q;
  assign status_error_framing = err_q;

endmodule

// File: tb/tb_pcie_tlp_cpl_fifo.sv
// Directed bench for pcie_tlp_cpl_fifo: a per-cycle vector table plus hand-written sequences
// for back-pressure, header exhaustion and mid-packet reset.
module tb_pcie_tlp_cpl_fifo;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] s_data = '0;
  logic [7:0]   s_strb = '0;
  logic [127:0] s_hdr = '0;
  logic         s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
  logic         s_ready;
  logic [255:0] tx_data;
  logic [7:0]   tx_strb;
  logic [127:0] tx_hdr;
  logic         tx_valid, tx_sop, tx_eop;
  logic         tx_ready = 1'b0;
  logic [2:0]   pkt_count;
  logic         err;

  int total = 0;
  int bad   = 0;

  pcie_tlp_cpl_fifo dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_tlp_data           (s_data),
    .s_tlp_strb           (s_strb),
    .s_tlp_hdr            (s_hdr),
    .s_tlp_valid          (s_valid),
    .s_tlp_sop            (s_sop),
    .s_tlp_eop            (s_eop),
    .s_tlp_ready          (s_ready),
    .tx_cpl_tlp_data      (tx_data),
    .tx_cpl_tlp_strb      (tx_strb),
    .tx_cpl_tlp_hdr       (tx_hdr),
    .tx_cpl_tlp_valid     (tx_valid),
    .tx_cpl_tlp_sop       (tx_sop),
    .tx_cpl_tlp_eop       (tx_eop),
    .tx_cpl_tlp_ready     (tx_ready),
    .pkt_count            (pkt_count),
    .status_error_framing (err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk_data(input logic [7:0] tag);
    return {8{24'hC0FFEE, tag}};
  endfunction

  function automatic logic [127:0] mk_hdr(input logic [7:0] htag);
    return {24'h4A0000, htag, 96'h0123456789ABCDEF00112233};
  endfunction

  function automatic logic [7:0] mk_strb(input logic [7:0] tag);
    return ~tag;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       v, sop, eop;
    logic [7:0] tag, htag;
    logic       rdy;
    logic       e_rdy, e_val, e_sop, e_eop;
    logic [7:0] e_tag, e_htag;
    int         e_pc;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(input logic v, sop, eop, input logic [7:0] tag, htag,
                              input logic rdy, input logic e_val, e_sop, e_eop,
                              input logic [7:0] e_tag, e_htag, input int e_pc,
                              input logic e_err);
    vec_t r;
    r.v = v; r.sop = sop; r.eop = eop; r.tag = tag; r.htag = htag; r.rdy = rdy;
    r.e_rdy = 1'b1; r.e_val = e_val; r.e_sop = e_sop; r.e_eop = e_eop;
    r.e_tag = e_tag; r.e_htag = e_htag; r.e_pc = e_pc; r.e_err = e_err;
    return r;
  endfunction

  typedef struct {
    logic [7:0] tag, htag;
    logic       sop, eop;
  } beat_t;

  beat_t exp_q[$];

  // Drive one beat once s_tlp_ready is seen; a bounded wait counts as a failure on expiry.
  task automatic send_beat(input logic sop, eop, input logic [7:0] tag, htag);
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("send_timeout", {255'b0, s_ready}, 256'd1);
    end else begin
      s_valid = 1'b1; s_sop = sop; s_eop = eop;
      s_data = mk_data(tag); s_strb = mk_strb(tag); s_hdr = mk_hdr(htag);
      @(posedge clk);
      #1 s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    end
  endtask

  task automatic expect_beat(input logic [7:0] tag, htag, input logic sop, eop);
    beat_t b;
    b.tag = tag; b.htag = htag; b.sop = sop; b.eop = eop;
    exp_q.push_back(b);
  endtask

  // Pop everything for n_exp + slack cycles and compare against exp_q in order.
  task automatic drain(input int slack);
    int cycles = exp_q.size() + slack;
    beat_t b;
    tx_ready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain_extra_beat", {248'b0, tx_data[7:0]}, 256'd0);
        end else begin
          b = exp_q.pop_front();
          chk("drain_data", tx_data, mk_data(b.tag));
          chk("drain_strb", {248'b0, tx_strb}, {248'b0, mk_strb(b.tag)});
          chk("drain_hdr", {128'b0, tx_hdr}, {128'b0, mk_hdr(b.htag)});
          chk("drain_sop", {255'b0, tx_sop}, {255'b0, b.sop});
          chk("drain_eop", {255'b0, tx_eop}, {255'b0, b.eop});
        end
      end
    end
    chk("drain_missing", exp_q.size(), 256'd0);
    exp_q.delete();
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    // Single-beat packet, framing drop, 4-beat packet with a stray sop and a one-cycle stall.
    //               v  sop eop tag    htag   rdy val sop eop e_tag  e_htag pc err
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 1, 8'h01, 8'h01, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h01, 8'h01, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h99, 8'h09, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h10, 8'h02, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h11, 8'h0E, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h12, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 1, 8'h13, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h10, 8'h02, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h11, 8'h02, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h11, 8'h02, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h12, 8'h02, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'h13, 8'h02, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));

    repeat (3) @(negedge clk);
    chk("reset_ready", {255'b0, s_ready}, 256'd0);
    chk("reset_valid", {255'b0, tx_valid}, 256'd0);
    chk("reset_pkt_count", {253'b0, pkt_count}, 256'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {255'b0, s_ready}, {255'b0, vecs[i].e_rdy});
      chk($sformatf("v%0d_valid", i), {255'b0, tx_valid}, {255'b0, vecs[i].e_val});
      chk($sformatf("v%0d_pkt_count", i), {253'b0, pkt_count}, 256'(vecs[i].e_pc));
      chk($sformatf("v%0d_err", i), {255'b0, err}, {255'b0, vecs[i].e_err});
      if (vecs[i].e_val) begin
        chk($sformatf("v%0d_sop", i), {255'b0, tx_sop}, {255'b0, vecs[i].e_sop});
        chk($sformatf("v%0d_eop", i), {255'b0, tx_eop}, {255'b0, vecs[i].e_eop});
        chk($sformatf("v%0d_data", i), tx_data, mk_data(vecs[i].e_tag));
        chk($sformatf("v%0d_strb", i), {248'b0, tx_strb}, {248'b0, mk_strb(vecs[i].e_tag)});
        chk($sformatf("v%0d_hdr", i), {128'b0, tx_hdr}, {128'b0, mk_hdr(vecs[i].e_htag)});
      end
      s_valid = vecs[i].v; s_sop = vecs[i].sop; s_eop = vecs[i].eop;
      s_data = mk_data(vecs[i].tag); s_strb = mk_strb(vecs[i].tag);
      s_hdr = mk_hdr(vecs[i].htag); tx_ready = vecs[i].rdy;
    end
    @(negedge clk);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; tx_ready = 1'b0;

    // Header exhaustion: four single-beat packets fill every header slot.
    for (int p = 0; p < 4; p++) send_beat(1'b1, 1'b1, 8'(8'h80 + p), 8'(8'h40 + p));
    @(negedge clk);
    chk("hdr_full_ready", {255'b0, s_ready}, 256'd0);
    chk("hdr_full_pkt_count", {253'b0, pkt_count}, 256'd4);
    chk("hdr_full_head", tx_data, mk_data(8'h80));
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("hdr_pop_ready", {255'b0, s_ready}, 256'd1);
    chk("hdr_pop_pkt_count", {253'b0, pkt_count}, 256'd3);
    send_beat(1'b1, 1'b1, 8'h84, 8'h44);
    for (int p = 1; p < 5; p++) expect_beat(8'(8'h80 + p), 8'(8'h40 + p), 1'b1, 1'b1);
    drain(4);

    // Data full: 4 + 4 + 8 in-progress beats fill all 16 data slots while in a packet.
    for (int b = 0; b < 4; b++) send_beat(b == 0, b == 3, 8'(8'h20 + b), 8'h21);
    for (int b = 0; b < 4; b++) send_beat(b == 0, b == 3, 8'(8'h30 + b), 8'h31);
    for (int b = 0; b < 8; b++) send_beat(b == 0, 1'b0, 8'(8'h50 + b), 8'h51);
    @(negedge clk);
    chk("data_full_ready", {255'b0, s_ready}, 256'd0);
    chk("data_full_pkt_count", {253'b0, pkt_count}, 256'd2);
    chk("data_full_head", tx_data, mk_data(8'h20));
    chk("data_full_head_sop", {255'b0, tx_sop}, 256'd1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("data_pop_ready", {255'b0, s_ready}, 256'd1);
    send_beat(1'b0, 1'b1, 8'h58, 8'h00);
    for (int b = 1; b < 4; b++) expect_beat(8'(8'h20 + b), 8'h21, 1'b0, b == 3);
    for (int b = 0; b < 4; b++) expect_beat(8'(8'h30 + b), 8'h31, b == 0, b == 3);
    for (int b = 0; b < 9; b++) expect_beat(8'(8'h50 + b), 8'h51, b == 0, b == 8);
    drain(4);

    // Reset with one stored packet and a partial one in flight.
    send_beat(1'b1, 1'b1, 8'h60, 8'h06);
    send_beat(1'b1, 1'b0, 8'h61, 8'h07);
    send_beat(1'b0, 1'b0, 8'h62, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", {255'b0, s_ready}, 256'd0);
    chk("rst_valid", {255'b0, tx_valid}, 256'd0);
    chk("rst_sop_eop", {254'b0, tx_sop, tx_eop}, 256'd0);
    chk("rst_pkt_count", {253'b0, pkt_count}, 256'd0);
    chk("rst_data", tx_data, 256'd0);
    chk("rst_strb_hdr", {120'b0, tx_strb, tx_hdr}, 256'd0);
    chk("rst_err", {255'b0, err}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {255'b0, s_ready}, 256'd1);
    send_beat(1'b1, 1'b1, 8'h70, 8'h08);
    @(negedge clk);
    chk("post_rst_pkt_count", {253'b0, pkt_count}, 256'd1);
    expect_beat(8'h70, 8'h08, 1'b1, 1'b1);
    drain(6);
    chk("post_rst_final_count", {253'b0, pkt_count}, 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
